arbiter_puf_sequencer: RTL and testbench
========================================

// Module: arbiter_puf_sequencer
// PURPOSE
// - Sequences an N-stage arbiter PUF: accepts a seed challenge (valid/ready), steps an LFSR through
//   RESP_W challenges, launches the race for each, samples the PUF response, and returns a RESP_W-bit word.
// - Sits directly upstream of the arbiter PUF (drives challenge, race, PUF reset) and consumes its response.
// PARAMETERS
// - N           64                     challenge width; equals the PUF stage count
// - RESP_W      32                     response bits per output word, >=1
// - SETTLE_CYC  8                      cycles race is held high before sampling; >=3 (covers 2-flop sync)
// - LFSR_TAPS   64'hD800_0000_0000_0000 Fibonacci feedback mask, width N
// PORTS
// - clk_i          in   1       clock
// - rstn_i         in   1       asynchronous active-low reset
// - ch_valid_i     in   1       seed challenge valid
// - ch_ready_o     out  1       seed accepted when valid&ready
// - ch_data_i      in   N       seed challenge
// - resp_valid_o   out  1       response word valid
// - resp_ready_i   in   1       consumer ready
// - resp_data_o    out  RESP_W  response word; bit k = response to k-th challenge
// - busy_o         out  1       high in every state except IDLE
// - puf_challenge_o out N       challenge to PUF, registered
// - puf_race_o     out  2       race signal to PUF, registered
// - puf_rstn_o     out  1       PUF arbiter reset, active-low, registered
// - puf_resp_i     in   1       PUF response, asynchronous to clk_i
// BEHAVIOUR
// - Reset (async, rstn_i=0): state IDLE; ch_ready_o=1, resp_valid_o=0, resp_data_o=0, busy_o=0,
//   puf_challenge_o=0, puf_race_o=2'b00, puf_rstn_o=0, LFSR=0, counters=0, sync flops=0.
// - puf_resp_i passes a 2-flop synchronizer at all times; only the synced value is used.
// - IDLE: ch_ready_o=1. On valid&ready: LFSR<=ch_data_i (all-zero seed replaced by N'd1), bit_cnt<=0 -> ARM.
// - ARM (1 cyc): puf_rstn_o=0, puf_race_o=00, puf_challenge_o<=LFSR -> RELEASE.
// - RELEASE (1 cyc): puf_rstn_o=1, race 00 -> LAUNCH.
// - LAUNCH (1 cyc): puf_race_o<=2'b11; settle counter<=SETTLE_CYC-1 -> SETTLE.
// - SETTLE (SETTLE_CYC cyc): race held 11, count down; at 0 -> SAMPLE.
// - SAMPLE (1 cyc): resp_shift[bit_cnt]<=synced bit; race<=00;
//   LFSR<={LFSR[N-2:0], ^(LFSR & LFSR_TAPS)}; if bit_cnt==RESP_W-1 -> OUT, else bit_cnt++ -> ARM.
// - OUT: resp_valid_o=1, resp_data_o stable; on resp_ready_i -> IDLE (resp_valid_o drops next cycle).
//   ch_ready_o=0 in all states except IDLE; no new seed accepted until word consumed.
// - Per-bit time SETTLE_CYC+4 cycles; seed accept to resp_valid_o = RESP_W*(SETTLE_CYC+4) cycles.
// - First challenge is the seed itself; LFSR steps only in SAMPLE; bit_cnt wraps to 0 on new seed.
// - resp_ready_i held high before OUT: word presented for exactly 1 cycle. ch_valid_i ignored while busy.
// - rstn_i asserted mid-operation: immediate abort to reset values; partial word discarded.
// CONFIGURATION
// - APUF_MAJORITY_VOTE_EN defined: each challenge evaluated 3 times (ARM..SAMPLE x3, same challenge);
//   stored bit = majority of 3 synced samples; LFSR steps only after 3rd; per-bit time 3*(SETTLE_CYC+4).
// - Undefined: single evaluation per challenge as above; no vote logic or vote counter synthesized.
// TESTING
// - Reset, no stimulus -> ch_ready_o=1, resp_valid_o=0, puf_rstn_o=0, puf_race_o=00 held indefinitely.
// - RESP_W=4, SETTLE_CYC=8, seed 64'h1, model PUF resp=challenge[0] -> resp_valid_o 48 cycles after
//   accept; resp_data_o=4'b0001 (LFSR 1,2,4,8); puf_challenge_o sequence 1,2,4,8.
// - Seed 0 -> first challenge driven is 64'h1; PUF model resp=1 constant -> resp_data_o all ones.
// - resp_ready_i=0 for 20 cycles in OUT -> resp_valid_o and resp_data_o stable; ch_ready_o=0; second
//   seed offered meanwhile accepted only on cycle after handshake.
// - rstn_i pulsed low during SETTLE of bit 2 -> outputs at reset values same cycle; fresh seed gives
//   correct full word with no stale bits.
// - APUF_MAJORITY_VOTE_EN, PUF model returns 1,0,1 for one challenge -> stored bit 1; 0,0,1 -> stored 0;
//   latency RESP_W*3*(SETTLE_CYC+4).

Source files
------------

// File: rtl/arbiter_puf_sequencer.sv
// arbiter_puf_sequencer: turns a seed challenge into a RESP_W-bit word by driving
// an N-stage arbiter PUF through an LFSR-generated challenge sequence.
// Per challenge the PUF is cleared (ARM), its reset is released (RELEASE), the race
// is launched (LAUNCH) and held (SETTLE), and the synchronised response is sampled
// (SAMPLE). The finished word is then held in OUT until the consumer takes it.
// Optional feature macro: APUF_MAJORITY_VOTE_EN. When it is defined, each challenge
// is evaluated three times and the stored bit is the majority of the three samples.
module arbiter_puf_sequencer #(
    parameter int           N          = 64,
    parameter int           RESP_W     = 32,
    parameter int           SETTLE_CYC = 8,
    parameter logic [N-1:0] LFSR_TAPS  = 64'hD800_0000_0000_0000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              ch_valid_i,
    output logic              ch_ready_o,
    input  logic [N-1:0]      ch_data_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [RESP_W-1:0] resp_data_o,
    output logic              busy_o,
    output logic [N-1:0]      puf_challenge_o,
    output logic [1:0]        puf_race_o,
    output logic              puf_rstn_o,
    input  logic              puf_resp_i
);

    localparam int BW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, ARM, RELEASE, LAUNCH, SETTLE, SAMPLE, OUT} state_t;

    state_t            state;
    logic [N-1:0]      lfsr;
    logic [BW-1:0]     bit_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [RESP_W-1:0] resp_shift;
    logic [RESP_W-1:0] next_shift;
    logic [1:0]        sync;
    logic              sample_bit;
    logic              last_eval;
`ifdef APUF_MAJORITY_VOTE_EN
    logic [1:0]        vote_cnt;
    logic [1:0]        votes;
`endif

    // Two-flop synchroniser on the asynchronous PUF response, always running
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sync <= 2'b00;
        else         sync <= {sync[0], puf_resp_i};
    end

    // Bit to store for this evaluation, and whether this evaluation completes the challenge
    always_comb begin
`ifdef APUF_MAJORITY_VOTE_EN
        sample_bit = (votes[0] & votes[1]) | (votes[0] & sync[1]) | (votes[1] & sync[1]);
        last_eval  = (vote_cnt == 2'd2);
`else
        sample_bit = sync[1];
        last_eval  = 1'b1;
`endif
    end

    // Response word with the current bit merged in, so OUT can present it in one step
    always_comb begin
        next_shift          = resp_shift;
        next_shift[bit_cnt] = sample_bit;
    end

    // Sequencer FSM; every PUF-facing and handshake output is registered here
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            ch_ready_o      <= 1'b1;
            resp_valid_o    <= 1'b0;
            resp_data_o     <= '0;
            busy_o          <= 1'b0;
            puf_challenge_o <= '0;
            puf_race_o      <= 2'b00;
            puf_rstn_o      <= 1'b0;
            lfsr            <= '0;
            bit_cnt         <= '0;
            settle_cnt      <= '0;
            resp_shift      <= '0;
`ifdef APUF_MAJORITY_VOTE_EN
            vote_cnt        <= 2'd0;
            votes           <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ch_valid_i && ch_ready_o) begin
                        // An all-zero LFSR would lock up, so a zero seed becomes 1
                        lfsr       <= (ch_data_i == '0) ? N'(1) : ch_data_i;
                        bit_cnt    <= '0;
                        resp_shift <= '0;
                        ch_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    puf_rstn_o      <= 1'b0;
                    puf_race_o      <= 2'b00;
                    puf_challenge_o <= lfsr;
                    state           <= RELEASE;
                end
                RELEASE: begin
                    puf_rstn_o <= 1'b1;
                    puf_race_o <= 2'b00;
                    state      <= LAUNCH;
                end
                LAUNCH: begin
                    puf_race_o <= 2'b11;
                    settle_cnt <= SW'(SETTLE_CYC - 1);
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) state <= SAMPLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                SAMPLE: begin
                    puf_race_o <= 2'b00;
`ifdef APUF_MAJORITY_VOTE_EN
                    if (!last_eval) begin
                        // Repeat the same challenge; keep this sample for the vote
                        votes[vote_cnt[0]] <= sync[1];
                        vote_cnt           <= vote_cnt + 2'd1;
                    end else begin
                        vote_cnt <= 2'd0;
                    end
`endif
                    if (!last_eval) begin
                        state <= ARM;
                    end else begin
                        resp_shift <= next_shift;
                        lfsr       <= {lfsr[N-2:0], ^(lfsr & LFSR_TAPS)};
                        if (bit_cnt == BW'(RESP_W - 1)) begin
                            resp_data_o  <= next_shift;
                            resp_valid_o <= 1'b1;
                            state        <= OUT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= ARM;
                        end
                    end
                end
                OUT: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        ch_ready_o   <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_puf_sequencer.sv
// tb_arbiter_puf_sequencer: drives seeds into arbiter_puf_sequencer with a small
// behavioural PUF model, queues the expected word for each accepted seed and
// compares it when the word is presented.
module tb_arbiter_puf_sequencer;

    localparam int N     = 64;
    localparam int RW    = 4;
    localparam int S     = 8;
`ifdef APUF_MAJORITY_VOTE_EN
    localparam int VOTES = 3;
`else
    localparam int VOTES = 1;
`endif
    localparam int BIT_T = VOTES * (S + 4);
    localparam logic [N-1:0] TAPS = 64'hD800_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ch_valid;
    logic          ch_ready;
    logic [N-1:0]  ch_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [RW-1:0] resp_data;
    logic          busy;
    logic [N-1:0]  puf_chal;
    logic [1:0]    puf_race;
    logic          puf_rstn;
    logic          puf_resp;

    int n_checks = 0;
    int n_pass   = 0;

    logic [RW-1:0] exp_q[$];
    logic [N-1:0]  chal_log[$];

    // PUF model: 0 = challenge bit 0, 1 = constant 1, 2 = scripted per-evaluation pattern
    int   puf_mode = 0;
    int   eval_cnt = 0;
    int   eval_base = 0;
    int   pat_idx;
    logic pat [12];
    logic [1:0] race_q = 2'b00;

    arbiter_puf_sequencer #(.N(N), .RESP_W(RW), .SETTLE_CYC(S), .LFSR_TAPS(TAPS)) dut (
        .clk_i(clk), .rstn_i(rstn), .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
        .ch_data_i(ch_data), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .busy_o(busy), .puf_challenge_o(puf_chal),
        .puf_race_o(puf_race), .puf_rstn_o(puf_rstn), .puf_resp_i(puf_resp)
    );

    always #5 clk = ~clk;

    always_comb begin
        pat_idx  = eval_cnt - eval_base - 1;
        puf_resp = 1'b0;
        case (puf_mode)
            0:       puf_resp = puf_chal[0];
            1:       puf_resp = 1'b1;
            default: if (pat_idx >= 0 && pat_idx < 12) puf_resp = pat[pat_idx];
        endcase
    end

    // Count race launches and log the challenge in force at each one
    always @(negedge clk) begin
        if (puf_race == 2'b11 && race_q != 2'b11) begin
            eval_cnt = eval_cnt + 1;
            chal_log.push_back(puf_chal);
        end
        race_q = puf_race;
    end

    // Reference word: walk the LFSR from the seed and apply the PUF model
    function automatic logic [RW-1:0] model_word(input logic [N-1:0] seed, input int mode);
        logic [N-1:0]  l;
        logic [RW-1:0] w;
        l = (seed == '0) ? N'(1) : seed;
        w = '0;
        for (int i = 0; i < RW; i++) begin
            w[i] = (mode == 1) ? 1'b1 : l[0];
            l = {l[N-2:0], ^(l & TAPS)};
        end
        return w;
    endfunction

    task automatic send_seed(input logic [N-1:0] seed, input logic [RW-1:0] exp);
        @(negedge clk);
        n_checks++;
        if (ch_ready !== 1'b1) $display("FAIL send_ready: ch_ready=%b required 1", ch_ready);
        else n_pass++;
        ch_valid = 1'b1;
        ch_data  = seed;
        exp_q.push_back(exp);
        @(negedge clk);
        ch_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input bit check_lat);
        int cyc = 0;
        logic [RW-1:0] exp;
        while (!resp_valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (!resp_valid) begin
            $display("FAIL %s_timeout: resp_valid=0 after %0d cycles", name, cyc);
            return;
        end
        n_pass++;
        if (check_lat) begin
            n_checks++;
            if (cyc !== RW * BIT_T)
                $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, RW * BIT_T);
            else n_pass++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (resp_data !== exp) $display("FAIL %s_data: got %b required %b", name, resp_data, exp);
        else n_pass++;
        if (resp_ready) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0) $display("FAIL %s_one_cycle: resp_valid=%b required 0", name, resp_valid);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; ch_valid = 1'b0; ch_data = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ch_ready, resp_valid, puf_rstn, puf_race, busy} !== 6'b100000)
                $display("FAIL reset_idle: rdy/vld/pufrst/race/busy=%b required 100000",
                         {ch_ready, resp_valid, puf_rstn, puf_race, busy});
            else n_pass++;
        end
        n_checks++;
        if (resp_data !== '0 || puf_chal !== '0)
            $display("FAIL reset_data: resp=%h chal=%h required 0", resp_data, puf_chal);
        else n_pass++;
    endtask

    task automatic test_basic();
        puf_mode = 0;
        chal_log.delete();
        send_seed(64'h1, 4'b0001);
        wait_resp("basic", 1'b1);
        for (int i = 0; i < RW; i++) begin
            n_checks++;
            if (chal_log.size() <= i * VOTES)
                $display("FAIL basic_chal%0d: no launch logged required %h", i, 64'h1 << i);
            else if (chal_log[i * VOTES] !== (64'h1 << i))
                $display("FAIL basic_chal%0d: got %h required %h", i, chal_log[i * VOTES], 64'h1 << i);
            else n_pass++;
        end
    endtask

    task automatic test_zero_seed();
        puf_mode = 1;
        chal_log.delete();
        send_seed(64'h0, 4'b1111);
        wait_resp("zero_seed", 1'b1);
        n_checks++;
        if (chal_log.size() == 0 || chal_log[0] !== 64'h1)
            $display("FAIL zero_seed_chal: got %h required 1", (chal_log.size() > 0) ? chal_log[0] : 'x);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [RW-1:0] held;
        puf_mode = 0;
        resp_ready = 1'b0;
        send_seed(64'hC000_0000_0000_0001, model_word(64'hC000_0000_0000_0001, 0));
        wait_resp("stall", 1'b1);
        held = resp_data;
        ch_valid = 1'b1;
        ch_data  = 64'h1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b1 || resp_data !== held || ch_ready !== 1'b0)
                $display("FAIL stall_hold: vld=%b data=%b rdy=%b required 1 %b 0",
                         resp_valid, resp_data, ch_ready, held);
            else n_pass++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ch_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL stall_handshake: busy=%b rdy=%b vld=%b required 0 1 0", busy, ch_ready, resp_valid);
        else n_pass++;
        exp_q.push_back(model_word(64'h1, 0));
        @(negedge clk);
        ch_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL stall_second_accept: busy=%b required 1", busy);
        else n_pass++;
        wait_resp("stall_second", 1'b0);
    endtask

    task automatic test_mid_reset();
        puf_mode = 1;
        send_seed(64'h1, 4'b1111);
        repeat (2 * BIT_T + 4) @(negedge clk);
        n_checks++;
        if (puf_race !== 2'b11) $display("FAIL midrst_settle: race=%b required 11", puf_race);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({ch_ready, resp_valid, busy, puf_race, puf_rstn} !== 6'b100000 || puf_chal !== '0 || resp_data !== '0)
            $display("FAIL midrst_values: rdy/vld/busy/race/pufrst=%b chal=%h resp=%b required 100000 0 0",
                     {ch_ready, resp_valid, busy, puf_race, puf_rstn}, puf_chal, resp_data);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        puf_mode = 0;
        send_seed(64'h1, 4'b0001);
        wait_resp("midrst_fresh", 1'b1);
    endtask

`ifdef APUF_MAJORITY_VOTE_EN
    task automatic test_vote();
        pat = '{1'b1, 1'b0, 1'b1,  1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0};
        eval_base = eval_cnt;
        puf_mode  = 2;
        send_seed(64'h1, 4'b0101);
        wait_resp("vote", 1'b1);
        n_checks++;
        if (eval_cnt - eval_base !== 3 * RW)
            $display("FAIL vote_evals: got %0d required %0d", eval_cnt - eval_base, 3 * RW);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_seed();
        test_stall();
        test_mid_reset();
`ifdef APUF_MAJORITY_VOTE_EN
        test_vote();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
